split_6_enum: RTL and testbench

- Sequential solution enumerator for the split_6 constraint group on var_7. It is the generating end of the interface whose consuming end is the combinational constraint check.
- Walks every candidate value of var_7 from 0 to 2^VAR_W-1 and evaluates constraints 9, 11 and 17 on each.
- Streams the satisfying values out over a valid/ready handshake, and counts solutions and rejects.
- Sits between the solver's sequencer (start/abort/done) and the downstream BDD/solution consumer.

---
 rtl/split_6_pkg.sv | 29 ++
 rtl/split_6_eval.sv | 15 +
 rtl/split_6_enum.sv | 118 +++++++++++
 tb/tb_split_6_enum.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/split_6_pkg.sv
// rtl/split_6_pkg.sv - shared constants, state enum and satisfiability function for split_6
package split_6_pkg;

    localparam logic [15:0] K9_MUL  = 16'd11;
    localparam logic [15:0] K11_OR  = 16'h0014;
    localparam logic [15:0] K17_ADD = 16'd4;
    localparam logic [15:0] K17_MUL = 16'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Arithmetic runs at 16 bits and is masked down to cw bits (cw <= 16),
    // which equals truncation to cw because only low bits feed low bits.
    function automatic logic split_6_sat(input logic [15:0] c, input int cw);
        logic [15:0] mask;
        logic        k9;
        logic        k11;
        logic        k17;
        mask = 16'((32'd1 << cw) - 32'd1);
        k9   = |(~(c * K9_MUL) & mask);
        k11  = |((c | K11_OR) & mask);
        k17  = |(((c + K17_ADD) * K17_MUL) & mask);
        return k9 & k11 & k17;
    endfunction

endpackage

// File: rtl/split_6_eval.sv
// rtl/split_6_eval.sv - combinational constraint check for one var_7 candidate
module split_6_eval
    import split_6_pkg::*;
#(
    parameter int VAR_W = 6
) (
    input  logic [VAR_W-1:0] c_i,
    output logic             sat_o
);

    localparam int CW = (VAR_W > 8) ? VAR_W : 8;

    assign sat_o = split_6_sat(16'(c_i), CW);

endmodule

// File: rtl/split_6_enum.sv
// rtl/split_6_enum.sv - walks all var_7 candidates and streams satisfying values
module split_6_enum
    import split_6_pkg::*;
#(
    parameter int VAR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAR_W-1:0] out_var_7,
    output logic [VAR_W:0]   sol_count,
    output logic [VAR_W:0]   rej_count
);

    state_e           state_q, state_d;
    logic [VAR_W-1:0] cand_q, cand_d;
    logic [VAR_W-1:0] var_q, var_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [VAR_W:0]   sol_q, sol_d;
    logic [VAR_W:0]   rej_q, rej_d;
    logic             sat;
    logic             slot_free;
    logic             xfer;
    logic             advance;

    split_6_eval #(.VAR_W(VAR_W)) u_eval (
        .c_i   (cand_q),
        .sat_o (sat)
    );

    assign slot_free = !valid_q || out_ready;
    assign xfer      = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        var_d   = var_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        sol_d   = sol_q;
        rej_d   = rej_q;
        advance = 1'b0;
        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cand_d  = '0;
                        sol_d   = '0;
                        rej_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (xfer) valid_d = 1'b0;
                    if (!sat) begin
                        rej_d   = rej_q + 1'b1;
                        advance = 1'b1;
                    end else if (slot_free) begin
                        var_d   = cand_q;
                        valid_d = 1'b1;
                        sol_d   = sol_q + 1'b1;
                        advance = 1'b1;
                    end
                    // The last candidate leaves cand_q in place rather than wrapping.
                    if (advance) begin
                        if (cand_q == {VAR_W{1'b1}}) state_d = DRAIN;
                        else                         cand_d  = cand_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (slot_free) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            var_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            sol_q   <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            var_q   <= var_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            sol_q   <= sol_d;
            rej_q   <= rej_d;
        end
    end

    assign busy      = (state_q == SCAN) || (state_q == DRAIN);
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_var_7 = var_q;
    assign sol_count = sol_q;
    assign rej_count = rej_q;

endmodule

// File: tb/tb_split_6_enum.sv
// tb/tb_split_6_enum.sv - directed self-checking bench for split_6_enum (VAR_W=6 and VAR_W=8)
module tb_split_6_enum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy, done, out_valid;
    logic [5:0] out_var_7;
    logic [6:0] sol_count, rej_count;

    logic       start8 = 1'b0;
    logic       abort8 = 1'b0;
    logic       ready8 = 1'b1;
    logic       busy8, done8, valid8;
    logic [7:0] var8;
    logic [8:0] sol8, rej8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    split_6_enum #(.VAR_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_var_7 (out_var_7),
        .sol_count (sol_count),
        .rej_count (rej_count)
    );

    split_6_enum #(.VAR_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .abort     (abort8),
        .busy      (busy8),
        .done      (done8),
        .out_valid (valid8),
        .out_ready (ready8),
        .out_var_7 (var8),
        .sol_count (sol8),
        .rej_count (rej8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp8;
        int cyc;
        int seen_done;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_var", 32'(out_var_7), 0);
        chk("rst_sol", 32'(sol_count), 0);
        chk("rst_rej", 32'(rej_count), 0);
        chk("rst_valid8", 32'(valid8), 0);
        rst_n = 1'b1;

        // Full scan with out_ready high: 0..63 back to back, first at start+2
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_busy", 32'(busy), 1);
        chk("lat_valid_early", 32'(out_valid), 0);
        tick();
        for (int i = 0; i < 64; i++) begin
            chk("seq_valid", 32'(out_valid), 1);
            chk("seq_var", 32'(out_var_7), 32'(i));
            tick();
        end
        chk("w6_done", 32'(done), 1);
        chk("w6_busy_after", 32'(busy), 0);
        chk("w6_valid_after", 32'(out_valid), 0);
        chk("w6_sol", 32'(sol_count), 64);
        chk("w6_rej", 32'(rej_count), 0);
        tick();
        chk("w6_done_one_cycle", 32'(done), 0);
        chk("w6_sol_held", 32'(sol_count), 64);
        chk("w6_var_held", 32'(out_var_7), 63);

        // VAR_W=8 scan: 93 and 252 are the only rejects
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        exp8 = 0;
        seen_done = 0;
        cyc = 0;
        while (cyc < 400 && seen_done == 0) begin
            tick();
            cyc++;
            if (done8) seen_done = 1;
            else if (valid8) begin
                chk("w8_var", 32'(var8), 32'(exp8));
                exp8++;
                if (exp8 == 93 || exp8 == 252) exp8++;
            end
        end
        chk("w8_done_seen", 32'(seen_done), 1);
        chk("w8_last_next", 32'(exp8), 256);
        chk("w8_sol", 32'(sol8), 254);
        chk("w8_rej", 32'(rej8), 2);
        chk("w8_busy_after", 32'(busy8), 0);

        // Back-pressure: hold out_ready low for 5 cycles after the first solution
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_var", 32'(out_var_7), 0);
            chk("stall_sol", 32'(sol_count), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("resume_var", 32'(out_var_7), 1);
        chk("resume_sol", 32'(sol_count), 2);
        tick();
        chk("resume_var2", 32'(out_var_7), 2);

        // Abort mid-scan, then restart; abort after the 10th transfer
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort1_busy", 32'(busy), 0);
        chk("abort1_valid", 32'(out_valid), 0);
        chk("abort1_sol", 32'(sol_count), 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_sol", 32'(sol_count), 0);
        tick();
        chk("restart_var", 32'(out_var_7), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_abort_var", 32'(out_var_7), 10);
        chk("pre_abort_sol", 32'(sol_count), 11);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_sol", 32'(sol_count), 11);
        tick();
        chk("abort_start_ignored", 32'(busy), 0);
        chk("abort_no_done", 32'(done), 0);
        chk("abort_sol_frozen", 32'(sol_count), 11);

        // Start while busy is ignored; then asynchronous reset mid-scan
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("scan2_sol_clear", 32'(sol_count), 0);
        tick();
        tick();
        tick();
        chk("busy_start_pre", 32'(out_var_7), 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_var", 32'(out_var_7), 3);
        chk("busy_start_sol", 32'(sol_count), 4);
        tick();
        chk("busy_start_var2", 32'(out_var_7), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_var", 32'(out_var_7), 0);
        chk("arst_sol", 32'(sol_count), 0);
        chk("arst_rej", 32'(rej_count), 0);
        chk("arst_done", 32'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
